main_memory: RTL
================

Name: main_memory

Overview:
- Byte-addressed, big-endian main memory that responds to the fetch/memory-stage request interface (address, read/write, access size).
- Serves one request per clock with one-cycle registered read latency.
- Clears its contents after reset and drives a busy flag that feeds the requester's stall input.
- Flags misaligned, out-of-range and reserved-size requests instead of executing them.

Parameters:
- BASE_ADDR, 32'h80020000, first byte address mapped by the memory.
- DEPTH_WORDS, 1024, number of 32-bit words stored; the mapped range is BASE_ADDR to BASE_ADDR+4*DEPTH_WORDS-1.
- CLEAR_ON_RESET, 1, 1 = zero every word after reset; 0 = skip the clear and become ready immediately.

Ports:
- clk_in  input  1  clock; all state changes on the rising edge.
- rst_in  input  1  synchronous, active-high reset.
- enable_in  input  1  request strobe; a request is accepted when 1 at a clock edge and the block is not busy.
- addr_in  input  32  byte address of the request.
- rw_in  input  1  0 = read, 1 = write.
- access_size_in  input  2  00 = byte, 01 = halfword, 10 = word, 11 = reserved.
- data_in  input  32  write data, right-aligned (byte in [7:0], halfword in [15:0]).
- data_out  output  32  read data, right-aligned and zero-extended.
- valid_out  output  1  one-cycle response pulse for each accepted request.
- error_out  output  1  qualifies valid_out: the request was rejected.
- busy_out  output  1  1 while clearing; requests are ignored while busy_out is 1.

Behaviour:
- Reset (rst_in=1 at an edge): data_out=0, valid_out=0, error_out=0, clear counter=0.
  - CLEAR_ON_RESET=1: state=INIT and busy_out=1.
  - CLEAR_ON_RESET=0: state=IDLE and busy_out=0.
  - Reset overrides everything, including mid-clear (the clear restarts at word 0) and mid-request (any pending response is dropped).
- State INIT:
  - Each cycle writes 0 to word[counter], then counter increments.
  - After the edge that writes word DEPTH_WORDS-1: state goes to IDLE and busy_out drops to 0, visible after that same edge.
  - The clear therefore takes exactly DEPTH_WORDS cycles.
  - enable_in is ignored; valid_out stays 0.
- State IDLE: a request is accepted at edge N when enable_in=1. The response is visible after edge N, for one cycle: valid_out=1.
  - Without a new request, valid_out=0 and error_out=0 after the next edge. data_out holds its last value.
- Index: offset = addr_in - BASE_ADDR (32-bit unsigned subtraction). word index = offset[31:2], byte lane = offset[1:0].
- Error conditions (checked in this order, all yield the same response):
  - access_size_in=11.
  - Halfword with offset[0]=1.
  - Word with offset[1:0]!=0.
  - addr_in < BASE_ADDR, or offset >= 4*DEPTH_WORDS.
  - Response: valid_out=1, error_out=1, data_out=0, no memory change.
- Big-endian lanes: lane 0 = bits [31:24], lane 1 = [23:16], lane 2 = [15:8], lane 3 = [7:0]. Halfword at lane 0 = [31:16]; halfword at lane 2 = [15:0].
- Read: data_out = selected byte/halfword/word, zero-extended. error_out=0.
- Write: only the addressed lanes change; other bytes of the word are preserved.
  - Response: valid_out=1, error_out=0, data_out=0.
- Ordering:
  - A write accepted at edge N is visible to a read accepted at edge N+1 (read-after-write, no bypass hazard).
  - Back-to-back requests on every cycle give full throughput, one response per cycle.
- No wrap-around: an address past the top of the range is an error and never aliases.

Test Plan:
- Reset with CLEAR_ON_RESET=1, DEPTH_WORDS=16; hold enable_in=1 read 0x80020000 -> busy_out=1 for exactly 16 cycles after reset, no valid_out meanwhile; first read then returns valid_out=1, data_out=0x00000000.
- Word write 0xDEADBEEF @0x80020004, then byte reads of lanes 0..3 on consecutive cycles -> responses 0xDE, 0xAD, 0xBE, 0xEF, one per cycle.
- Byte write 0x55 @0x80020006 over 0xDEADBEEF, then word read @0x80020004 -> 0xDEAD55EF.
- Halfword read @0x80020005 -> error_out=1, data_out=0. Word read @0x8001FFFC -> error_out=1. access_size_in=11 -> error_out=1. Word write @0x80020040 with DEPTH_WORDS=16 -> error_out=1 and memory unchanged.
- Word write @0x80020008 at edge N, word read of the same address at edge N+1 -> new data returned at N+2 response.
- Assert rst_in at clear counter=7 -> clear restarts: busy_out stays 1 for 16 more cycles; previously written data reads back 0.

Source files
------------

// File: rtl/main_memory.sv
// Byte-addressed big-endian main memory with one-cycle registered read
// latency, post-reset clear sequence and rejection of bad requests.
module main_memory #(
  parameter logic [31:0] BASE_ADDR      = 32'h8002_0000,
  parameter int unsigned DEPTH_WORDS    = 1024,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        enable_in,
  input  logic [31:0] addr_in,
  input  logic        rw_in,
  input  logic [1:0]  access_size_in,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        valid_out,
  output logic        error_out,
  output logic        busy_out
);

  localparam int unsigned   CW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(DEPTH_WORDS - 1);

  typedef enum logic {
    ST_INIT,
    ST_IDLE
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] clr_cnt;
  logic [31:0]   mem [DEPTH_WORDS];

  logic [31:0]   offset;
  logic [29:0]   word_idx;
  logic [1:0]    lane;
  logic [CW-1:0] idx;
  logic          out_of_range;
  logic          bad_size;
  logic          bad_align;
  logic          req_err;
  logic          accept;
  logic          do_write;
  logic [31:0]   rd_word;
  logic [31:0]   rd_shift;
  logic [31:0]   rdata;
  logic [31:0]   wdata;
  logic [3:0]    be;

  // Address decode and request validation
  always_comb begin
    offset       = addr_in - BASE_ADDR;
    word_idx     = offset[31:2];
    lane         = offset[1:0];
    idx          = word_idx[CW-1:0];
    out_of_range = (addr_in < BASE_ADDR) || (32'(word_idx) >= DEPTH_WORDS);
    bad_size     = (access_size_in == 2'b11);
    bad_align    = ((access_size_in == 2'b01) && lane[0]) ||
                   ((access_size_in == 2'b10) && (lane != 2'b00));
    req_err      = bad_size || bad_align || out_of_range;
    accept       = (state == ST_IDLE) && enable_in;
    do_write     = accept && rw_in && !req_err && !rst_in;
  end

  // Big-endian lane selection for reads and byte enables for writes;
  // be[i] covers bits [8*i+7:8*i], so lane 0 maps to be[3]
  always_comb begin
    rd_word  = mem[idx];
    rd_shift = rd_word >> {~lane, 3'b000};
    rdata    = '0;
    wdata    = '0;
    be       = '0;
    case (access_size_in)
      2'b00: begin
        rdata = {24'b0, rd_shift[7:0]};
        wdata = {4{data_in[7:0]}};
        be    = 4'b1000 >> lane;
      end
      2'b01: begin
        rdata = lane[1] ? {16'b0, rd_word[15:0]} : {16'b0, rd_word[31:16]};
        wdata = {2{data_in[15:0]}};
        be    = lane[1] ? 4'b0011 : 4'b1100;
      end
      2'b10: begin
        rdata = rd_word;
        wdata = data_in;
        be    = 4'b1111;
      end
      default: begin
        rdata = '0;
        wdata = '0;
        be    = '0;
      end
    endcase
  end

  // Next-state logic: clear runs until the last word is zeroed
  always_comb begin
    state_next = state;
    busy_out   = (state == ST_INIT);
    case (state)
      ST_INIT: if (clr_cnt == LAST_IDX) state_next = ST_IDLE;
      ST_IDLE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_in) begin
    if (rst_in) state <= CLEAR_ON_RESET ? ST_INIT : ST_IDLE;
    else        state <= state_next;
  end

  // Clear counter, advancing one word per cycle while clearing
  always_ff @(posedge clk_in) begin
    if (rst_in)                 clr_cnt <= '0;
    else if (state == ST_INIT)  clr_cnt <= clr_cnt + CW'(1);
  end

  // Response register: one pulse per accepted request, data held otherwise
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      data_out  <= '0;
      valid_out <= 1'b0;
      error_out <= 1'b0;
    end else begin
      valid_out <= accept;
      if (accept) begin
        error_out <= req_err;
        data_out  <= (req_err || rw_in) ? '0 : rdata;
      end else begin
        error_out <= 1'b0;
      end
    end
  end

  // Storage: clear sweep or lane-masked write
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      if (state == ST_INIT) begin
        mem[clr_cnt] <= '0;
      end else if (do_write) begin
        for (int unsigned i = 0; i < 4; i++) begin
          if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

endmodule
